// File: rtl/spi_tx_scheduler.sv
// Drains TX FIFO words into a byte-level SPI master, framing each burst with cs_n
// and enforcing chip-select setup and inter-frame gap timing.
module spi_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int CS_SETUP   = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [$clog2(MAX_BURST):0]  burst_len,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic                        fifo_empty,
  output logic                        fifo_read_enable,
  output logic                        spi_start,
  output logic [DATA_WIDTH-1:0]       spi_data,
  input  logic                        spi_busy,
  input  logic                        spi_done,
  output logic                        cs_n,
  output logic                        frame_done,
  output logic                        underrun,
  output logic                        busy
);

  localparam int RW   = $clog2(MAX_BURST) + 1;
  localparam int TMAX = (CS_SETUP > GAP_CYCLES) ? CS_SETUP : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [RW-1:0] MAX_BURST_W = RW'(MAX_BURST);
  localparam logic [TW-1:0] SETUP_LAST  = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    WAIT_DONE,
    GAP
  } state_t;

  state_t                state_reg, state_next;
  logic [RW-1:0]         remaining_reg, remaining_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic                  cs_n_reg, cs_n_next;
  logic [DATA_WIDTH-1:0] spi_data_reg, spi_data_next;
  logic                  spi_start_reg, spi_start_next;
  logic                  fifo_read_enable_reg, fifo_read_enable_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  underrun_reg, underrun_next;
  logic                  busy_reg, busy_next;
  logic [RW-1:0]         remaining_dec;

  assign remaining_dec = remaining_reg - RW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg            <= IDLE;
      remaining_reg        <= '0;
      timer_reg            <= '0;
      cs_n_reg             <= 1'b1;
      spi_data_reg         <= '0;
      spi_start_reg        <= 1'b0;
      fifo_read_enable_reg <= 1'b0;
      frame_done_reg       <= 1'b0;
      underrun_reg         <= 1'b0;
      busy_reg             <= 1'b0;
    end else begin
      state_reg            <= state_next;
      remaining_reg        <= remaining_next;
      timer_reg            <= timer_next;
      cs_n_reg             <= cs_n_next;
      spi_data_reg         <= spi_data_next;
      spi_start_reg        <= spi_start_next;
      fifo_read_enable_reg <= fifo_read_enable_next;
      frame_done_reg       <= frame_done_next;
      underrun_reg         <= underrun_next;
      busy_reg             <= busy_next;
    end
  end

  always_comb begin
    state_next            = state_reg;
    remaining_next        = remaining_reg;
    timer_next            = timer_reg;
    cs_n_next             = cs_n_reg;
    spi_data_next         = spi_data_reg;
    spi_start_next        = 1'b0;
    fifo_read_enable_next = 1'b0;
    frame_done_next       = 1'b0;
    underrun_next         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable && !fifo_empty && (burst_len != '0)) begin
          remaining_next = (burst_len > MAX_BURST_W) ? MAX_BURST_W : burst_len;
          cs_n_next      = 1'b0;
          timer_next     = TW'(1);
          // The LOAD cycle itself is the last setup clock before the strobe.
          state_next     = (CS_SETUP <= 1) ? LOAD : SETUP;
        end
      end

      SETUP: begin
        if (timer_reg >= SETUP_LAST) begin
          timer_next = '0;
          state_next = LOAD;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      LOAD: begin
        if (fifo_empty) begin
          cs_n_next     = 1'b1;
          underrun_next = 1'b1;
          timer_next    = '0;
          state_next    = GAP;
        end else if (!spi_busy) begin
          spi_data_next         = fifo_data;
          spi_start_next        = 1'b1;
          fifo_read_enable_next = 1'b1;
          state_next            = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (spi_done) begin
          remaining_next = remaining_dec;
          if (remaining_dec == '0) begin
            cs_n_next       = 1'b1;
            frame_done_next = 1'b1;
            timer_next      = '0;
            state_next      = GAP;
          end else if (!enable) begin
            cs_n_next  = 1'b1;
            timer_next = '0;
            state_next = GAP;
          end else begin
            state_next = LOAD;
          end
        end
      end

      GAP: begin
        if (timer_reg >= GAP_LAST) begin
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      default: begin
        cs_n_next  = 1'b1;
        timer_next = '0;
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign cs_n             = cs_n_reg;
  assign spi_data         = spi_data_reg;
  assign spi_start        = spi_start_reg;
  assign fifo_read_enable = fifo_read_enable_reg;
  assign frame_done       = frame_done_reg;
  assign underrun         = underrun_reg;
  assign busy             = busy_reg;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Scoreboard bench for spi_tx_scheduler: FIFO and SPI master models, a monitor that
// pops expected events, and directed frame scenarios with hand-computed results.
module tb_spi_tx_scheduler;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int BW = $clog2(MB) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic          spi_start;
  logic [DW-1:0] spi_data;
  logic          spi_busy;
  logic          spi_done = 1'b0;
  logic          cs_n;
  logic          frame_done;
  logic          underrun;
  logic          busy;

  spi_tx_scheduler #(
    .DATA_WIDTH(DW), .MAX_BURST(MB), .CS_SETUP(2), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .burst_len(burst_len),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable),
    .spi_start(spi_start), .spi_data(spi_data), .spi_busy(spi_busy), .spi_done(spi_done),
    .cs_n(cs_n), .frame_done(frame_done), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // FIFO model: combinational head, pop on the edge where the strobe is seen.
  logic [DW-1:0] fmem [0:63];
  int fhead = 0;
  int ftail = 0;
  int pops = 0;
  assign fifo_empty = (fhead == ftail);
  assign fifo_data  = fifo_empty ? 8'h00 : fmem[fhead[5:0]];

  task automatic push(input logic [DW-1:0] d);
    fmem[ftail[5:0]] = d;
    ftail = ftail + 1;
  endtask

  always @(posedge clk) begin
    if (fifo_read_enable) begin
      check("pop_nonempty", 32'(fifo_empty), 0);
      fhead <= fhead + 1;
      pops  <= pops + 1;
    end
  end

  // SPI master model: 3 busy clocks per byte, then a one-cycle done.
  logic model_busy = 1'b0;
  logic hold_busy = 1'b0;
  int   spi_cnt = 0;
  assign spi_busy = model_busy | hold_busy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_busy <= 1'b0;
      spi_done   <= 1'b0;
      spi_cnt    <= 0;
    end else begin
      spi_done <= 1'b0;
      if (spi_start) begin
        model_busy <= 1'b1;
        spi_cnt    <= 3;
      end else if (model_busy) begin
        if (spi_cnt == 1) begin
          model_busy <= 1'b0;
          spi_done   <= 1'b1;
        end
        spi_cnt <= spi_cnt - 1;
      end
    end
  end

  // Scoreboard: kind 0 = spi_start(data), 1 = frame_done, 2 = underrun.
  // lat is cycles from cs_n fall (first byte) or last spi_done; -1 skips it.
  typedef struct {
    int          kind;
    logic [7:0]  data;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_ev(input int kind, input logic [7:0] d, input int lat);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  int   cyc = 0;
  int   cs_fall_cyc = 0;
  int   done_cyc = 0;
  logic prev_cs_n = 1'b1;
  logic prev_start = 1'b0;
  logic first_byte = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic handle_event(input int kind);
    exp_t e;
    int   ref_cyc;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none (cyc %0d)",
               kind, spi_data, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == 0 && kind == 0) check("spi_data", 32'(spi_data), 32'(e.data));
      if (e.lat >= 0) begin
        ref_cyc = (kind == 0 && first_byte) ? cs_fall_cyc : done_cyc;
        check("event_latency", 32'(cyc - ref_cyc), 32'(e.lat));
      end
    end
  endtask

  always @(negedge clk) begin
    if (prev_cs_n && !cs_n) begin
      cs_fall_cyc = cyc;
      first_byte  = 1'b1;
    end
    if (spi_done) done_cyc = cyc;
    if (spi_start || fifo_read_enable) check("start_pop_pair", 32'(fifo_read_enable), 32'(spi_start));
    if (spi_start) begin
      check("no_back2back_start", 32'(prev_start), 0);
      handle_event(0);
      first_byte = 1'b0;
    end
    if (frame_done) handle_event(1);
    if (underrun) handle_event(2);
    prev_cs_n  = cs_n;
    prev_start = spi_start;
  end

  function automatic logic cond(input int sel);
    case (sel)
      0: return spi_start;
      1: return frame_done;
      2: return underrun;
      3: return !cs_n;
      default: return cs_n;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int maxc, input string name);
    bit hit = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (cond(sel)) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      $display("FAIL timeout %s: event not seen within %0d cycles", name, maxc);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_spi_start", 32'(spi_start), 0);
    check("rst_pop", 32'(fifo_read_enable), 0);
    check("rst_spi_data", 32'(spi_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_underrun", 32'(underrun), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Two-byte burst, full frame.
    push(8'hA5);
    push(8'h3C);
    expect_ev(0, 8'hA5, 2);
    expect_ev(0, 8'h3C, 2);
    expect_ev(1, 8'h00, 1);
    burst_len = BW'(2);
    enable = 1'b1;
    wait_for(1, 60, "t1_frame_done");
    check("t1_cs_gap0", 32'(cs_n), 1);
    @(negedge clk); check("t1_cs_gap1", 32'(cs_n), 1);
    @(negedge clk); check("t1_cs_gap2", 32'(cs_n), 1);
    @(negedge clk); check("t1_cs_gap3", 32'(cs_n), 1);
    check("t1_busy_in_gap", 32'(busy), 1);
    @(negedge clk); check("t1_idle_busy", 32'(busy), 0);
    check("t1_pops", 32'(pops), 2);
    check("t1_sb_drained", 32'(exp_q.size()), 0);

    // Underrun: one word available for a 3-word burst.
    enable = 1'b0;
    push(8'h5A);
    expect_ev(0, 8'h5A, 2);
    expect_ev(2, 8'h00, 2);
    burst_len = BW'(3);
    enable = 1'b1;
    wait_for(2, 60, "t2_underrun");
    check("t2_cs_rise", 32'(cs_n), 1);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("t2_pops", 32'(pops), 3);
    check("t2_sb_drained", 32'(exp_q.size()), 0);

    // Enable dropped during the first byte: abort after it, no frame_done.
    push(8'h11);
    push(8'h22);
    expect_ev(0, 8'h11, 2);
    burst_len = BW'(2);
    enable = 1'b1;
    wait_for(0, 40, "t3_start");
    enable = 1'b0;
    wait_for(4, 40, "t3_cs_rise");
    check("t3_no_frame_done", 32'(frame_done), 0);
    repeat (8) @(negedge clk);
    check("t3_pops", 32'(pops), 4);
    check("t3_word_left", 32'(fifo_empty), 0);
    check("t3_sb_drained", 32'(exp_q.size()), 0);

    // SPI busy stall in LOAD; start and pop fire together on release.
    hold_busy = 1'b1;
    expect_ev(0, 8'h22, -1);
    expect_ev(1, 8'h00, 1);
    burst_len = BW'(1);
    enable = 1'b1;
    wait_for(3, 40, "t4_cs_fall");
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_start", 32'(spi_start), 0);
      check("t4_stall_pop", 32'(fifo_read_enable), 0);
    end
    hold_busy = 1'b0;
    @(negedge clk);
    check("t4_release_start", 32'(spi_start), 1);
    check("t4_release_pop", 32'(fifo_read_enable), 1);
    wait_for(1, 40, "t4_frame_done");
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_pops", 32'(pops), 5);
    check("t4_sb_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset in WAIT_DONE.
    push(8'h77);
    push(8'h88);
    expect_ev(0, 8'h77, 2);
    burst_len = BW'(2);
    enable = 1'b1;
    wait_for(0, 40, "t5_start");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_cs_n", 32'(cs_n), 1);
    check("t5_async_busy", 32'(busy), 0);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_cs_idle", 32'(cs_n), 1);
    check("t5_pops", 32'(pops), 6);
    check("t5_sb_drained", 32'(exp_q.size()), 0);

    // burst_len = 0 never starts a frame.
    burst_len = '0;
    enable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("t6_cs_n", 32'(cs_n), 1);
    end
    check("t6_pops", 32'(pops), 6);

    // Leftover word goes out once a non-zero length is given.
    expect_ev(0, 8'h88, 2);
    expect_ev(1, 8'h00, 1);
    burst_len = BW'(1);
    wait_for(1, 40, "t7_frame_done");
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("t7_pops", 32'(pops), 7);
    check("t7_sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Drains bytes from a transmit FIFO (the team's `fifo` block) into a byte-level SPI master.
- Frames bursts with chip-select.
- Enforces CS setup and inter-frame gap timing.
- Sits between the host-side TX FIFO and the SPI shift engine, and is the only block that pops the TX FIFO.

Parameters:
DATA_WIDTH, 8, width of FIFO words and SPI bytes
MAX_BURST, 16, largest burst length in words per CS frame
CS_SETUP, 2, clocks between cs_n falling and first spi_start (>=1)
GAP_CYCLES, 4, clocks cs_n held high after a frame before the next may start (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; permits new frames, deassert to end current frame
burst_len  in  $clog2(MAX_BURST)+1  words per frame, sampled at frame start
fifo_data  in  DATA_WIDTH  FIFO head word (combinational FIFO output)
fifo_empty  in  1  FIFO empty flag
fifo_read_enable  out  1  one-cycle pop strobe to FIFO
spi_start  out  1  one-cycle start strobe to SPI master
spi_data  out  DATA_WIDTH  byte to shift, valid while spi_start high and held until the next load
spi_busy  in  1  SPI master shifting
spi_done  in  1  one-cycle pulse at end of byte
cs_n  out  1  chip select, active low
frame_done  out  1  one-cycle pulse, frame completed with full burst
underrun  out  1  one-cycle pulse, frame ended early due to empty FIFO
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0):
  - state=IDLE, cs_n=1, spi_data=0, counters=0.
  - fifo_read_enable, spi_start, frame_done, underrun and busy are all 0.
  - Takes effect immediately, including mid-frame.
  - The SPI master and FIFO are reset by their own resets; no pop is issued during reset.
- FSM states: IDLE, SETUP, LOAD, WAIT_DONE, GAP.
- IDLE:
  - Start condition: enable=1, fifo_empty=0 and burst_len!=0.
  - On start: latch remaining=min(burst_len, MAX_BURST), cs_n<=0, go to SETUP.
  - burst_len=0 never starts a frame.
- SETUP: count CS_SETUP clocks with cs_n low, then go to LOAD.
- LOAD:
  - If fifo_empty=0 and spi_busy=0 (single cycle):
    - spi_data<=fifo_data, spi_start<=1, fifo_read_enable<=1.
    - Go to WAIT_DONE.
    - fifo_data is sampled in the same cycle the pop strobe is issued; the FIFO advances on the next edge.
  - If fifo_empty=1: cs_n<=1, underrun pulse, go to GAP.
  - If spi_busy=1: stall in LOAD.
- WAIT_DONE: on spi_done, remaining<=remaining-1. Exit depends on the new count and enable:
  - remaining reaches 0: cs_n<=1, frame_done pulse, go to GAP.
  - Otherwise, enable=0: cs_n<=1, go to GAP with no frame_done (graceful abort; the in-flight byte always completes).
  - Otherwise: go to LOAD.
- Back-to-back bytes: spi_done to next spi_start is exactly 2 clocks (WAIT_DONE to LOAD to strobe) when the FIFO is not empty.
- GAP: cs_n=1 for GAP_CYCLES clocks, then go to IDLE.
- Frame-to-frame: a new frame may begin from IDLE on the cycle after GAP ends.
- Exactly one fifo_read_enable per spi_start; never pop while fifo_empty=1.
- spi_start and fifo_read_enable are never high for two consecutive cycles.
- burst_len and enable changes mid-frame:
  - burst_len changes mid-frame are ignored.
  - An enable drop during SETUP is not seen until LOAD/WAIT_DONE: the frame still sends one byte, then ends.
- A spurious spi_done outside WAIT_DONE is ignored.
- Counter widths:
  - remaining is $clog2(MAX_BURST)+1 bits.
  - Timing counters are sized to max(CS_SETUP, GAP_CYCLES).
  - No wrap is possible.

Test Plan:
- Reset then FIFO holding 0xA5,0x3C, burst_len=2, enable=1:
  - cs_n falls, spi_start 2 clocks later with spi_data=0xA5, one pop.
  - After spi_done, spi_start with 0x3C 2 clocks later.
  - After the second spi_done: frame_done=1, cs_n=1 held 4 clocks, busy=0.
- FIFO holding 1 word, burst_len=3: one byte sent, then underrun pulse, cs_n rises, exactly 1 pop total.
- burst_len=2, enable dropped during first WAIT_DONE: first byte completes, no second spi_start, cs_n rises, frame_done=0.
- Hold spi_busy=1 for 5 clocks in LOAD: no spi_start and no pop until spi_busy falls, then both fire in the same cycle.
- reset_n asserted mid WAIT_DONE: cs_n=1 and busy=0 immediately (asynchronously, before the next clk edge); no pop after release until a new start condition.
- burst_len=0 with non-empty FIFO and enable=1 for 20 clocks: cs_n stays 1, no pops.
